round_referee: RTL and testbench
================================

Name: round_referee

Overview:
- Sits directly upstream of the game state machine and produces its round-outcome inputs (Reset_Round, Blue_W, Red_W).
- Consumes crash flags from the bike/collision logic and the current Game_State.
- Judges each round (blue win, red win or draw) and keeps the best-of-N match score.
- Freezes bike motion during a post-crash hold, then either restarts the round or declares the match winner.

Parameters:
- WINS_TO_MATCH, 3: round wins needed to take the match; legal range 1 to 2^SCORE_W-1.
- END_DELAY_FRAMES, 60: frame ticks held after a round is decided before any output pulse; must be at least 1.
- SCORE_W, 3: width of the score counters.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- Game_State  in  3  current game state: 0 Menu, 1 Round_Paused, 2 Round_Started, 3 Blue_Wins, 4 Red_Wins.
- frame_tick  in  1  one-Clk pulse per video frame.
- Blue_Crash  in  1  blue bike collided this cycle (level).
- Red_Crash  in  1  red bike collided this cycle (level).
- Reset_Round  out  1  registered one-cycle pulse: round over, match continues.
- Blue_W  out  1  registered one-cycle pulse: blue takes the match.
- Red_W  out  1  registered one-cycle pulse: red takes the match.
- blue_score  out  SCORE_W  blue round wins.
- red_score  out  SCORE_W  red round wins.
- round_result  out  2  outcome of the last round: 00 none, 01 blue, 10 red, 11 draw.
- freeze  out  1  high while the post-crash hold is running; bikes must not move.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, named Reset.
- On Reset: FSM goes to IDLE; all outputs, both scores and all internal counters are 0.
- Score clear: blue_score and red_score clear synchronously on any cycle with Game_State == Menu. Otherwise they hold, including through the Blue_Wins/Red_Wins screens, so the final score stays displayable.
- FSM states: IDLE, PLAY, JUDGE, HOLD, WAIT_EXIT.
  - IDLE: when Game_State == Round_Started, go to PLAY and clear round_result to 00.
  - PLAY: crash = Blue_Crash | Red_Crash.
    - Crash with frame_tick in the same cycle: latch the flags and decide immediately, going to HOLD.
    - Crash without frame_tick: latch the flags and go to JUDGE.
  - JUDGE: OR incoming crash flags into the latches every cycle. On frame_tick (that cycle's flags included), decide and go to HOLD. Crashes within one frame therefore count as simultaneous.
  - Decision:
    - Only blue crashed: result 10, red_score +1.
    - Only red crashed: result 01, blue_score +1.
    - Both crashed: result 11, no score change.
    - round_result updates on the decision cycle.
  - HOLD: freeze = 1. The frame counter starts at 0 and increments on each frame_tick. On the tick where count == END_DELAY_FRAMES-1, the block does the following in one cycle:
    - Emit exactly one one-cycle pulse:
      - Blue_W if blue_score == WINS_TO_MATCH.
      - Red_W if red_score == WINS_TO_MATCH.
      - Otherwise Reset_Round.
    - Drop freeze.
    - Go to WAIT_EXIT.
  - WAIT_EXIT: outputs idle; go to IDLE once Game_State != Round_Started. This prevents a false restart while the downstream state register updates.
- Pulse timing: pulses are registered and asserted for exactly one Clk. The downstream state machine leaves Round_Started on the following edge.
- Scores saturate at WINS_TO_MATCH and never wrap. At most one score increments per decision, so simultaneous match win is impossible; a draw never produces Blue_W or Red_W.
- Abort: if Game_State leaves Round_Started while in PLAY, JUDGE or HOLD (for example Reset_Game to Menu), go to IDLE the next cycle.
  - freeze goes to 0 and no pulse is emitted.
  - A score already incremented is kept unless Menu clears it.
- Crash flags are ignored in IDLE, HOLD and WAIT_EXIT.

Decomposition:
- tron_pkg contains:
  - the game_state_t encoding (Menu through Red_Wins, 3 bits) shared with the game state machine;
  - round_result_t (NONE, BLUE, RED, DRAW);
  - referee FSM state typedef.
- One sub-module: frame_delay_counter (start, frame_tick, Clk, Reset → done pulse), parameterised by END_DELAY_FRAMES. It is reused by the HOLD state.

Test Plan:
- Game_State = 2; Red_Crash pulsed mid-frame → round_result = 01, blue_score = 1, freeze high for 60 ticks, then Reset_Round high exactly 1 cycle on the 60th tick.
- Blue_Crash, then Red_Crash 5 cycles later, before the next frame_tick → round_result = 11, scores unchanged, Reset_Round after hold, no Blue_W/Red_W.
- Blue reaches 3 wins (three red crashes, Game_State cycled 2 → 1 → 2 between rounds) → third hold ends with Blue_W for 1 cycle, no Reset_Round; blue_score = 3 persists with Game_State = 3; Game_State = 0 → both scores 0.
- Crash and frame_tick in the same cycle → decision that cycle, HOLD entered next cycle, no JUDGE visit.
- Game_State forced to 0 during HOLD → freeze 0 next cycle, no pulses ever, FSM in IDLE.
- Reset asserted during JUDGE → next cycle all outputs 0, scores 0; later crash with Game_State != 2 → ignored.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared encodings for the game state machine and the round referee.
package tron_pkg;

    // Game state encoding owned by the downstream game state machine.
    typedef enum logic [2:0] {
        GsMenu         = 3'd0,
        GsRoundPaused  = 3'd1,
        GsRoundStarted = 3'd2,
        GsBlueWins     = 3'd3,
        GsRedWins      = 3'd4
    } game_state_t;

    // Outcome of the most recently judged round.
    typedef enum logic [1:0] {
        ResNone = 2'b00,
        ResBlue = 2'b01,
        ResRed  = 2'b10,
        ResDraw = 2'b11
    } round_result_t;

    // Referee FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StJudge,
        StHold,
        StWaitExit
    } ref_state_t;

endpackage

// File: rtl/frame_delay_counter.sv
// Counts frame ticks after a start pulse; done fires on the END_DELAY_FRAMES-th tick.
module frame_delay_counter #(
    parameter int unsigned END_DELAY_FRAMES = 60
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    input  logic frame_tick,
    output logic done
);

    localparam int unsigned CNT_W = (END_DELAY_FRAMES > 1) ? $clog2(END_DELAY_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(END_DELAY_FRAMES - 1);

    logic [CNT_W-1:0] count_q;
    logic             running_q;

    assign done = running_q && frame_tick && (count_q == LAST);

    // Start always rearms from zero, so a stale run left by an abort is harmless.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            count_q   <= '0;
            running_q <= 1'b1;
        end else if (done) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (running_q && frame_tick) begin
            count_q   <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/round_referee.sv
// Judges each round from crash flags, keeps the match score and drives the
// round-outcome pulses consumed by the game state machine.
module round_referee
    import tron_pkg::*;
#(
    parameter int unsigned WINS_TO_MATCH    = 3,
    parameter int unsigned END_DELAY_FRAMES = 60,
    parameter int unsigned SCORE_W          = 3
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [2:0]         Game_State,
    input  logic               frame_tick,
    input  logic               Blue_Crash,
    input  logic               Red_Crash,
    output logic               Reset_Round,
    output logic               Blue_W,
    output logic               Red_W,
    output logic [SCORE_W-1:0] blue_score,
    output logic [SCORE_W-1:0] red_score,
    output logic [1:0]         round_result,
    output logic               freeze
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WINS_TO_MATCH);

    ref_state_t         state_q, state_d;
    round_result_t      result_q, result_d;
    logic [SCORE_W-1:0] blue_q, blue_d, red_q, red_d;
    logic               blue_lat_q, blue_lat_d, red_lat_q, red_lat_d;
    logic               reset_round_q, reset_round_d;
    logic               blue_w_q, blue_w_d, red_w_q, red_w_d;
    logic               hold_start, hold_done;
    logic               decide, dec_blue, dec_red;
    logic               started;

    assign started = (Game_State == GsRoundStarted);

    frame_delay_counter #(
        .END_DELAY_FRAMES(END_DELAY_FRAMES)
    ) u_hold_counter (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (hold_start),
        .frame_tick(frame_tick),
        .done      (hold_done)
    );

    // Next-state, round judgement, scoring and pulse generation.
    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        blue_d        = blue_q;
        red_d         = red_q;
        blue_lat_d    = blue_lat_q;
        red_lat_d     = red_lat_q;
        reset_round_d = 1'b0;
        blue_w_d      = 1'b0;
        red_w_d       = 1'b0;
        hold_start    = 1'b0;
        decide        = 1'b0;
        dec_blue      = 1'b0;
        dec_red       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (started) begin
                    state_d    = StPlay;
                    result_d   = ResNone;
                    blue_lat_d = 1'b0;
                    red_lat_d  = 1'b0;
                end
            end
            StPlay: begin
                if (!started) begin
                    state_d = StIdle;
                end else if (Blue_Crash || Red_Crash) begin
                    blue_lat_d = Blue_Crash;
                    red_lat_d  = Red_Crash;
                    if (frame_tick) begin
                        decide   = 1'b1;
                        dec_blue = Blue_Crash;
                        dec_red  = Red_Crash;
                    end else begin
                        state_d = StJudge;
                    end
                end
            end
            StJudge: begin
                // Crashes landing within the same frame are treated as simultaneous.
                if (!started) begin
                    state_d = StIdle;
                end else begin
                    blue_lat_d = blue_lat_q | Blue_Crash;
                    red_lat_d  = red_lat_q | Red_Crash;
                    if (frame_tick) begin
                        decide   = 1'b1;
                        dec_blue = blue_lat_q | Blue_Crash;
                        dec_red  = red_lat_q | Red_Crash;
                    end
                end
            end
            StHold: begin
                if (!started) begin
                    state_d = StIdle;
                end else if (hold_done) begin
                    state_d = StWaitExit;
                    if (blue_q == WIN) begin
                        blue_w_d = 1'b1;
                    end else if (red_q == WIN) begin
                        red_w_d = 1'b1;
                    end else begin
                        reset_round_d = 1'b1;
                    end
                end
            end
            StWaitExit: begin
                // Wait for the game state machine to leave Round_Started before rearming.
                if (!started) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (decide) begin
            state_d    = StHold;
            hold_start = 1'b1;
            if (dec_blue && dec_red) begin
                result_d = ResDraw;
            end else if (dec_blue) begin
                result_d = ResRed;
                red_d    = (red_q == WIN) ? red_q : red_q + 1'b1;
            end else begin
                result_d = ResBlue;
                blue_d   = (blue_q == WIN) ? blue_q : blue_q + 1'b1;
            end
        end

        if (Game_State == GsMenu) begin
            blue_d = '0;
            red_d  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= StIdle;
            result_q      <= ResNone;
            blue_q        <= '0;
            red_q         <= '0;
            blue_lat_q    <= 1'b0;
            red_lat_q     <= 1'b0;
            reset_round_q <= 1'b0;
            blue_w_q      <= 1'b0;
            red_w_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            result_q      <= result_d;
            blue_q        <= blue_d;
            red_q         <= red_d;
            blue_lat_q    <= blue_lat_d;
            red_lat_q     <= red_lat_d;
            reset_round_q <= reset_round_d;
            blue_w_q      <= blue_w_d;
            red_w_q       <= red_w_d;
        end
    end

    assign Reset_Round  = reset_round_q;
    assign Blue_W       = blue_w_q;
    assign Red_W        = red_w_q;
    assign blue_score   = blue_q;
    assign red_score    = red_q;
    assign round_result = result_q;
    assign freeze       = (state_q == StHold);

endmodule

// File: tb/tb_round_referee.sv
// Self-checking bench for round_referee: cycle vector table plus scoreboard of
// expected outcome pulses, with hand sequences for abort and reset corners.
module tb_round_referee;

    localparam int unsigned END_FRAMES = 60;

    logic       Clk;
    logic       Reset;
    logic [2:0] Game_State;
    logic       frame_tick;
    logic       Blue_Crash;
    logic       Red_Crash;
    logic       Reset_Round;
    logic       Blue_W;
    logic       Red_W;
    logic [2:0] blue_score;
    logic [2:0] red_score;
    logic [1:0] round_result;
    logic       freeze;

    round_referee #(
        .WINS_TO_MATCH   (3),
        .END_DELAY_FRAMES(END_FRAMES),
        .SCORE_W         (3)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Game_State  (Game_State),
        .frame_tick  (frame_tick),
        .Blue_Crash  (Blue_Crash),
        .Red_Crash   (Red_Crash),
        .Reset_Round (Reset_Round),
        .Blue_W      (Blue_W),
        .Red_W       (Red_W),
        .blue_score  (blue_score),
        .red_score   (red_score),
        .round_result(round_result),
        .freeze      (freeze)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pulse codes as {Blue_W, Red_W, Reset_Round}.
    localparam logic [2:0] P_NONE = 3'b000;
    localparam logic [2:0] P_RR   = 3'b001;
    localparam logic [2:0] P_BW   = 3'b100;

    typedef struct {
        logic [2:0] gs;
        logic       tk;
        logic       bc;
        logic       rc;
        logic [1:0] res;
        logic [2:0] bs;
        logic [2:0] rs;
        logic       frz;
        logic [2:0] push;
    } vec_t;

    typedef struct {
        logic [2:0] pulse;
        logic [2:0] bs;
        logic [2:0] rs;
        logic [1:0] res;
    } sb_t;

    int   n_checks = 0;
    int   n_errors = 0;
    sb_t  sb[$];
    vec_t vecs[31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, then sample after the edge and score any outcome pulse.
    task automatic step(input logic [2:0] gs, input logic tk, input logic bc, input logic rc);
        logic [2:0] pv;
        sb_t        e;
        Game_State = gs;
        frame_tick = tk;
        Blue_Crash = bc;
        Red_Crash  = rc;
        @(posedge Clk);
        #1;
        pv = {Blue_W, Red_W, Reset_Round};
        if (pv !== P_NONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, pv}, {29'd0, P_NONE});
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {29'd0, pv}, {29'd0, e.pulse});
                chk("pulse_blue_score", {29'd0, blue_score}, {29'd0, e.bs});
                chk("pulse_red_score", {29'd0, red_score}, {29'd0, e.rs});
                chk("pulse_result", {30'd0, round_result}, {30'd0, e.res});
            end
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] res, input logic [2:0] bs,
                             input logic [2:0] rs, input logic frz);
        chk({tag, "_result"}, {30'd0, round_result}, {30'd0, res});
        chk({tag, "_blue"}, {29'd0, blue_score}, {29'd0, bs});
        chk({tag, "_red"}, {29'd0, red_score}, {29'd0, rs});
        chk({tag, "_freeze"}, {31'd0, freeze}, {31'd0, frz});
    endtask

    // Run the post-crash hold; crashes injected here must be ignored.
    task automatic hold_round(input vec_t v);
        for (int k = 1; k <= int'(END_FRAMES); k++) begin
            step(v.gs, 1'b0, (k == 3), (k == 7));
            chk("hold_freeze", {31'd0, freeze}, 32'd1);
            step(v.gs, 1'b1, 1'b0, 1'b0);
            chk($sformatf("hold_freeze_tick%0d", k), {31'd0, freeze},
                (k < int'(END_FRAMES)) ? 32'd1 : 32'd0);
        end
        chk("pulse_emitted", sb.size(), 32'd0);
        chk_state("after_hold", v.res, v.bs, v.rs, 1'b0);
        step(v.gs, 1'b1, 1'b0, 1'b0);
        chk("wait_exit_freeze", {31'd0, freeze}, 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] gs, input logic tk, input logic bc,
                                input logic rc, input logic [1:0] res, input logic [2:0] bs,
                                input logic [2:0] rs, input logic frz, input logic [2:0] push);
        vec_t v;
        v.gs = gs; v.tk = tk; v.bc = bc; v.rc = rc;
        v.res = res; v.bs = bs; v.rs = rs; v.frz = frz; v.push = push;
        return v;
    endfunction

    initial begin
        //             gs tk bc rc res bs rs frz push
        vecs[0]  = mk(2, 0, 0, 0, 0, 0, 0, 0, P_NONE); // IDLE -> PLAY
        vecs[1]  = mk(2, 1, 0, 0, 0, 0, 0, 0, P_NONE); // tick without crash
        vecs[2]  = mk(2, 0, 0, 1, 0, 0, 0, 0, P_NONE); // red crash mid-frame -> JUDGE
        vecs[3]  = mk(2, 0, 0, 0, 0, 0, 0, 0, P_NONE);
        vecs[4]  = mk(2, 1, 0, 0, 1, 1, 0, 1, P_RR);   // decide: blue wins round
        vecs[5]  = mk(1, 0, 0, 0, 1, 1, 0, 0, P_NONE); // WAIT_EXIT -> IDLE
        vecs[6]  = mk(2, 0, 0, 0, 0, 1, 0, 0, P_NONE); // result cleared on new round
        vecs[7]  = mk(2, 0, 1, 0, 0, 1, 0, 0, P_NONE); // blue crash
        vecs[8]  = mk(2, 0, 0, 0, 0, 1, 0, 0, P_NONE);
        vecs[9]  = mk(2, 0, 0, 0, 0, 1, 0, 0, P_NONE);
        vecs[10] = mk(2, 0, 0, 0, 0, 1, 0, 0, P_NONE);
        vecs[11] = mk(2, 0, 0, 0, 0, 1, 0, 0, P_NONE);
        vecs[12] = mk(2, 0, 0, 1, 0, 1, 0, 0, P_NONE); // red crash 5 cycles later
        vecs[13] = mk(2, 1, 0, 0, 3, 1, 0, 1, P_RR);   // draw
        vecs[14] = mk(1, 0, 0, 0, 3, 1, 0, 0, P_NONE);
        vecs[15] = mk(2, 1, 0, 1, 0, 1, 0, 0, P_NONE); // crash in IDLE ignored
        vecs[16] = mk(2, 1, 0, 1, 1, 2, 0, 1, P_RR);   // crash + tick: immediate HOLD
        vecs[17] = mk(1, 0, 0, 0, 1, 2, 0, 0, P_NONE);
        vecs[18] = mk(2, 0, 0, 0, 0, 2, 0, 0, P_NONE);
        vecs[19] = mk(2, 1, 0, 1, 1, 3, 0, 1, P_BW);   // third win -> Blue_W
        vecs[20] = mk(3, 0, 0, 0, 1, 3, 0, 0, P_NONE); // Blue_Wins screen keeps score
        vecs[21] = mk(3, 1, 0, 0, 1, 3, 0, 0, P_NONE);
        vecs[22] = mk(2, 0, 0, 0, 0, 3, 0, 0, P_NONE);
        vecs[23] = mk(2, 1, 0, 1, 1, 3, 0, 1, P_BW);   // saturates at 3
        vecs[24] = mk(3, 0, 0, 0, 1, 3, 0, 0, P_NONE);
        vecs[25] = mk(0, 0, 0, 0, 1, 0, 0, 0, P_NONE); // Menu clears scores
        vecs[26] = mk(2, 0, 0, 0, 0, 0, 0, 0, P_NONE);
        vecs[27] = mk(2, 1, 1, 0, 2, 0, 1, 1, P_NONE); // blue crash: red wins round
        vecs[28] = mk(2, 1, 0, 0, 2, 0, 1, 1, P_NONE); // hold running
        vecs[29] = mk(0, 0, 0, 0, 2, 0, 0, 0, P_NONE); // abort to Menu during HOLD
        vecs[30] = mk(2, 0, 0, 0, 0, 0, 0, 0, P_NONE); // back in IDLE -> PLAY

        Reset      = 1'b1;
        Game_State = 3'd0;
        frame_tick = 1'b0;
        Blue_Crash = 1'b0;
        Red_Crash  = 1'b0;
        step(3'd2, 1'b1, 1'b1, 1'b1);
        step(3'd2, 1'b0, 1'b0, 1'b0);
        chk_state("reset", 2'd0, 3'd0, 3'd0, 1'b0);
        chk("reset_pulses", {29'd0, Blue_W, Red_W, Reset_Round}, 32'd0);
        Reset = 1'b0;
        step(3'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 31; i++) begin
            if (vecs[i].push != P_NONE) begin
                sb.push_back('{pulse: vecs[i].push, bs: vecs[i].bs, rs: vecs[i].rs,
                               res: vecs[i].res});
            end
            step(vecs[i].gs, vecs[i].tk, vecs[i].bc, vecs[i].rc);
            chk_state($sformatf("row%0d", i), vecs[i].res, vecs[i].bs, vecs[i].rs,
                      vecs[i].frz);
            if (vecs[i].push != P_NONE) hold_round(vecs[i]);
        end

        // Stale hold after the abort must never produce a pulse.
        for (int k = 0; k < 70; k++) begin
            step(3'd1, 1'b1, 1'b0, 1'b0);
            chk("post_abort_freeze", {31'd0, freeze}, 32'd0);
        end

        // Abort via Round_Paused keeps the score already awarded.
        step(3'd2, 1'b0, 1'b0, 1'b0);
        step(3'd2, 1'b1, 1'b0, 1'b1);
        chk_state("pause_hold", 2'd1, 3'd1, 3'd0, 1'b1);
        step(3'd1, 1'b0, 1'b0, 1'b0);
        chk_state("pause_abort", 2'd1, 3'd1, 3'd0, 1'b0);

        // Reset asserted while judging.
        step(3'd2, 1'b0, 1'b0, 1'b0);
        step(3'd2, 1'b0, 1'b1, 1'b0);
        chk_state("judge", 2'd0, 3'd1, 3'd0, 1'b0);
        Reset = 1'b1;
        step(3'd2, 1'b1, 1'b0, 1'b0);
        chk_state("judge_reset", 2'd0, 3'd0, 3'd0, 1'b0);
        chk("judge_reset_pulses", {29'd0, Blue_W, Red_W, Reset_Round}, 32'd0);
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(3'd1, k[0], k[1], ~k[1]);
            chk_state("idle_crash", 2'd0, 3'd0, 3'd0, 1'b0);
        end
        step(3'd2, 1'b0, 1'b1, 1'b1);
        chk_state("enter_play", 2'd0, 3'd0, 3'd0, 1'b0);
        step(3'd2, 1'b1, 1'b0, 1'b0);
        chk_state("play_no_latch", 2'd0, 3'd0, 3'd0, 1'b0);
        step(3'd0, 1'b0, 1'b0, 1'b0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
